// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the core LSU (master 0) and a
// secondary bus master such as a loader or DMA engine (master 1). One master,
// or none, is granted per cycle with zero latency. Read data from the
// synchronous memory is steered back to the master that issued the read.
// Master 1 may lock the port, but while master 0 is waiting the lock is
// force-released after MAX_LOCK consecutive locked grants.
//
// Ports
//   clk_i, rstn_i            clock, synchronous active-low reset
//   mX_en_i                  access request from master X
//   mX_addr_i / mX_read_i    address, 1 = read / 0 = write
//   mX_wsel_byte_i           write byte enables
//   mX_wdata_i               write data
//   m1_lock_i                master 1 wants to keep the grant on later cycles
//   mX_gnt_o                 request accepted this cycle
//   mX_rvalid_o / mX_rdata_o read response, one cycle after a read grant
//   dmem_*_o                 memory port (all zero when nothing is granted)
//   dmem_rdata_i             memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 8
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                m0_en_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic                m0_read_i,
   input  logic [DATA_W/8-1:0] m0_wsel_byte_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic                m1_en_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic                m1_read_i,
   input  logic [DATA_W/8-1:0] m1_wsel_byte_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic                m1_lock_i,
   output logic                m0_gnt_o,
   output logic                m1_gnt_o,
   output logic                m0_rvalid_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                dmem_en_o,
   output logic [ADDR_W-1:0]   dmem_addr_o,
   output logic                dmem_read_o,
   output logic [DATA_W/8-1:0] dmem_wsel_byte_o,
   output logic [DATA_W-1:0]   dmem_wdata_o,
   input  logic [DATA_W-1:0]   dmem_rdata_i
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

   typedef enum logic {
      MST_0 = 1'b0,
      MST_1 = 1'b1
   } master_e;

   master_e          last_q, last_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   // Set when master 1 was granted last cycle with its lock request raised.
   logic             lock_q, lock_d;
   logic [1:0]       rsp_owner_q, rsp_owner_d;

   logic             gnt0, gnt1;
   logic             lock_active;
   logic [1:0]       rsp_valid;
   logic [DATA_W-1:0] rdata_mst [2];

   // Grant decision. Reset forces all grants low regardless of requests.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      // Dropping m1_lock_i releases the lock in the very same cycle.
      lock_active = lock_q & m1_lock_i;
      if (rstn_i) begin
         if (m0_en_i && !m1_en_i) begin
            gnt0 = 1'b1;
         end else if (m1_en_i && !m0_en_i) begin
            gnt1 = 1'b1;
         end else if (m0_en_i && m1_en_i) begin
            if (lock_active) begin
               // Forced release once the locked run reaches its bound.
               if (lock_cnt_q < LOCK_MAX) gnt1 = 1'b1;
               else                       gnt0 = 1'b1;
            end else if (last_q == MST_1) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end
      end
   end

   // Next-state logic for the arbitration and response-tracking registers.
   always_comb begin
      last_d      = last_q;
      lock_cnt_d  = '0;
      lock_d      = gnt1 & m1_lock_i;
      rsp_owner_d = {gnt1 & m1_read_i, gnt0 & m0_read_i};

      if (gnt0) last_d = MST_0;
      if (gnt1) last_d = MST_1;

      // Only contended locked grants consume the lock budget; an uncontended
      // lock keeps whatever count it has.
      if (gnt1 && m1_lock_i) begin
         if (!m0_en_i)                    lock_cnt_d = lock_cnt_q;
         else if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + CNT_W'(1);
         else                             lock_cnt_d = LOCK_MAX;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         last_q      <= MST_1;     // master 0 wins the first contention
         lock_cnt_q  <= '0;
         lock_q      <= 1'b0;
         rsp_owner_q <= 2'b00;
      end else begin
         last_q      <= last_d;
         lock_cnt_q  <= lock_cnt_d;
         lock_q      <= lock_d;
         rsp_owner_q <= rsp_owner_d;
      end
   end

   // Memory port mux; everything is zero when nothing is granted.
   always_comb begin
      dmem_en_o        = 1'b0;
      dmem_addr_o      = '0;
      dmem_read_o      = 1'b0;
      dmem_wsel_byte_o = '0;
      dmem_wdata_o     = '0;
      if (gnt0) begin
         dmem_en_o        = 1'b1;
         dmem_addr_o      = m0_addr_i;
         dmem_read_o      = m0_read_i;
         dmem_wsel_byte_o = m0_wsel_byte_i;
         dmem_wdata_o     = m0_wdata_i;
      end else if (gnt1) begin
         dmem_en_o        = 1'b1;
         dmem_addr_o      = m1_addr_i;
         dmem_read_o      = m1_read_i;
         dmem_wsel_byte_o = m1_wsel_byte_i;
         dmem_wdata_o     = m1_wdata_i;
      end
   end

   assign m0_gnt_o = gnt0;
   assign m1_gnt_o = gnt1;

   // A response pending across a reset assertion is dropped by this mask.
   assign rsp_valid = rsp_owner_q & {2{rstn_i}};

   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rdata_mst[gi] = rsp_valid[gi] ? dmem_rdata_i : '0;
   end

   assign m0_rvalid_o = rsp_valid[0];
   assign m1_rvalid_o = rsp_valid[1];
   assign m0_rdata_o  = rdata_mst[0];
   assign m1_rdata_o  = rdata_mst[1];

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single DMEM port between the core LSU (master 0) and a secondary bus master such as a loader or DMA engine (master 1). It sits in the platform between the LSU address decoder's DMEM branch and the memory macro. It grants one master per cycle, routes the synchronous-memory read data back to the master that issued the read, and bounds how long master 1 can hold the memory with a lock. It contains a round-robin pointer, a bounded lock counter and a one-deep response-owner register.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; the byte-select width is DATA_W/8
- MAX_LOCK, 8, maximum number of consecutive locked master-1 grants while master 0 is waiting; must be ≥1
- clk_i  in  1  clock; single clock domain
- rstn_i  in  1  reset, synchronous, active-low
- m0_en_i / m1_en_i  in  1  access request
- m0_addr_i / m1_addr_i  in  ADDR_W  address
- m0_read_i / m1_read_i  in  1  1 = read, 0 = write
- m0_wsel_byte_i / m1_wsel_byte_i  in  DATA_W/8  write byte enables
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m1_lock_i  in  1  master 1 requests to keep the grant on following cycles
- m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle
- m0_rvalid_o / m1_rvalid_o  out  1  read data valid this cycle
- m0_rdata_o / m1_rdata_o  out  DATA_W  read data
- dmem_en_o, dmem_addr_o, dmem_read_o, dmem_wsel_byte_o, dmem_wdata_o  out  1/ADDR_W/1/DATA_W/8/DATA_W  memory port
- dmem_rdata_i  in  DATA_W  memory read data, valid the cycle after an enabled read

## Operation
- State registers:
  - last_q: master granted most recently. Resets to M1, so master 0 wins the first contention.
  - lock_cnt_q: width $clog2(MAX_LOCK+1), reset value 0.
  - rsp_owner_q: 2 bits, one-hot {m1,m0}, reset value 00.
- Grant decision is combinational from the inputs and the registered state. Exactly one master or neither is granted.
  - Only one master requesting: that master is granted.
  - Both requesting, lock active and lock_cnt_q < MAX_LOCK: master 1 is granted.
    - Lock active means master 1 was granted last cycle with m1_lock_i=1.
  - Both requesting, lock active and lock_cnt_q == MAX_LOCK: master 0 is granted (forced release).
  - Both requesting, lock inactive: the master that is not last_q is granted (round-robin).
- Update of last_q: on any grant, last_q ← the granted master. If there is no grant, it holds.
- Update of lock_cnt_q:
  - Master 1 granted with m1_lock_i=1 while m0_en_i=1: increment, saturating at MAX_LOCK.
  - Master 1 granted with m1_lock_i=1 while m0_en_i=0: hold.
  - Any other case, including a forced release: clear to 0.
- Memory port:
  - dmem_en_o = 1 whenever a grant occurs.
  - dmem_addr_o, dmem_read_o, dmem_wsel_byte_o and dmem_wdata_o are muxed from the granted master.
  - With no grant, all memory-port outputs are 0.
  - On a read (dmem_read_o=1), dmem_wsel_byte_o is forwarded unchanged; the memory ignores it.
- Response routing:
  - rsp_owner_q ← the one-hot of the granted master if the grant is a read, else 00.
  - mX_rvalid_o = rsp_owner_q[X].
  - mX_rdata_o = dmem_rdata_i when rsp_owner_q[X]=1, else 0.
- Writes produce no rvalid.
- A request that is not granted is not queued. The master must hold en/addr/data until it sees gnt.

## Timing
- Grant is issued in the same cycle as the request (zero-latency) when there is no contention.
- Read data is returned exactly 1 cycle after the grant, on the requester's rvalid.
- Back-to-back reads from alternating masters are supported at full throughput. rsp_owner_q tracks every cycle independently.
- While rstn_i=0:
  - all registers take their reset values on the clock edge;
  - all gnt, rvalid and rdata outputs and all dmem_* outputs are forced to 0 combinationally, regardless of requests.
- Reset asserted the cycle after a read grant: the pending rvalid is dropped (rsp_owner_q cleared). No response is delivered after reset.
- Master 1 dropping m1_lock_i: the lock releases in the same cycle, and round-robin applies immediately.
- A locked master 1 that deasserts m1_en_i for one cycle loses the lock. lock_cnt_q clears and last_q is unchanged.
- Starvation bound: master 0 waits at most MAX_LOCK cycles under lock, or 1 cycle without lock.

## Test plan
- Reset then solo traffic:
  - Hold rstn_i=0 with m0_en_i=1: m0_gnt_o=0 and dmem_en_o=0.
  - Release reset, m0 reads 0x100: m0_gnt_o=1 that cycle; the next cycle m0_rvalid_o=1 and m0_rdata_o equals the memory word, while m1_rvalid_o=0.
- Round-robin:
  - Both masters read continuously with no lock: grants alternate m0, m1, m0, m1 starting with m0.
  - Each rvalid arrives on the matching master one cycle after its grant.
- Lock bound (MAX_LOCK=8):
  - m1 holds en=1 and lock=1 while m0 requests continuously.
  - m1 is granted 8 consecutive cycles after the first lock grant, then m0 is granted on the 9th contended cycle and lock_cnt_q clears.
- Lock without contention:
  - m1 locks for 20 cycles with m0_en_i=0: m1 is granted on all 20, and lock_cnt_q stays 0.
- Write/read mix:
  - m0 writes 0xDEADBEEF with wsel=4'b1111 to 0x40, then m1 reads 0x40.
  - m1_rdata_o=0xDEADBEEF the cycle after m1's grant. No rvalid is generated for the write.
- Mid-read reset:
  - Assert rstn_i=0 on the cycle after an m1 read grant: m1_rvalid_o=0.
  - After release, the first contended grant goes to m0.
